// File: rtl/hdbn_decode.sv
// HDBn line decoder: strips 000V / B00V zero-run substitutions from a ternary
// symbol stream, emits the recovered bits P_N accepts later, and counts code errors.
module hdbn_decode #(
  parameter int P_N         = 3,
  parameter int P_ERR_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [1:0]             i_code,
  input  logic                   i_code_vld,
  input  logic                   i_clr_cnt,
  output logic                   o_data,
  output logic                   o_data_vld,
  output logic                   o_err,
  output logic [P_ERR_CNT_W-1:0] o_err_cnt
);

  localparam int FILL_W = $clog2(P_N + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(P_N);

  // Symbol / polarity encoding; SYM_ZERO doubles as "no polarity seen yet".
  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_ILL  = 2'b11;

  // Handshake: i_code is consumed on every cycle with i_code_vld=1 (no
  // back-pressure); o_data is valid only in the cycle o_data_vld=1.

  logic [P_N-1:0][1:0] win_sym;
  logic [P_N-1:0]      win_bit;
  logic [FILL_W-1:0]   fill;
  logic [1:0]          last_mark;
  logic [1:0]          last_viol;

  logic [1:0] sym;
  logic       illegal;
  logic       is_mark;
  logic       is_viol;
  logic       tail_zero;
  logic       all_zero;
  logic       viol_ok;
  logic       match_000v;
  logic       match_b00v;
  logic       code_err;
  logic       new_bit;
  logic       out_bit;

  always_comb begin
    illegal   = (i_code == SYM_ILL);
    sym       = illegal ? SYM_ZERO : i_code;
    is_mark   = (sym != SYM_ZERO);
    is_viol   = is_mark && (last_mark == sym);

    tail_zero = 1'b1;
    for (int i = 1; i < P_N; i++) begin
      if (win_sym[i] != SYM_ZERO) tail_zero = 1'b0;
    end
    all_zero  = tail_zero && (win_sym[0] == SYM_ZERO);

    // last_viol == SYM_ZERO (none yet) never equals a mark polarity.
    viol_ok    = (last_viol != sym);
    match_000v = is_viol && viol_ok && all_zero;
    match_b00v = is_viol && viol_ok && tail_zero && (win_sym[0] == sym);

    code_err = illegal || (is_viol && !match_000v && !match_b00v);
    new_bit  = is_mark && !match_000v && !match_b00v;
    // A matched B00V means the oldest entry was the balancing B pulse.
    out_bit  = win_bit[0] && !match_b00v;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_sym    <= '0;
      win_bit    <= '0;
      fill       <= '0;
      last_mark  <= SYM_ZERO;
      last_viol  <= SYM_ZERO;
      o_data     <= 1'b0;
      o_data_vld <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_data_vld <= 1'b0;
      o_err      <= 1'b0;
      if (i_code_vld) begin
        win_sym    <= {sym, win_sym[P_N-1:1]};
        win_bit    <= {new_bit, win_bit[P_N-1:1]};
        o_data     <= out_bit;
        o_data_vld <= (fill == FILL_FULL);
        o_err      <= code_err;
        if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
        if (is_mark) last_mark <= sym;
        if (match_000v || match_b00v) last_viol <= sym;
      end
    end
  end

  // Clear has priority over a coincident error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_cnt <= '0;
    end else if (i_clr_cnt) begin
      o_err_cnt <= '0;
    end else if (i_code_vld && code_err && (o_err_cnt != {P_ERR_CNT_W{1'b1}})) begin
      o_err_cnt <= o_err_cnt + P_ERR_CNT_W'(1);
    end
  end

endmodule
